path_result_streamer: RTL and testbench
=======================================

# path_result_streamer

Synthesizable result-dump engine for the shortest-path core. After the solver finishes, it walks the path result memory from a base address. It classifies each word as a node, an unreachable marker (all-ones) or the terminator (zero), and streams the words out over a valid/ready interface. A negative-cycle flag from the solver short-circuits the walk into a single status beat, so host-side extraction no longer needs simulation-only scanning.

## Interface
Parameters:
- DATA_W, 16, result word width
- ADDR_W, 14, result memory address width
- BASE_ADDR, 0, first address read
- MAX_LEN, 16383, maximum words read before forced termination (1..2^ADDR_W−BASE_ADDR)

Ports:
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin a walk; sampled only in IDLE
- n_exist  in  1  solver negative-cycle flag; sampled with start
- mem_rd_en  out  1  result memory read strobe
- mem_addr  out  ADDR_W  read address
- mem_rdata  in  DATA_W  read data, valid one cycle after mem_rd_en
- out_valid  out  1  beat valid
- out_ready  in  1  sink accepts beat
- out_data  out  DATA_W  beat payload
- out_kind  out  2  0 NODE, 1 UNREACH, 2 TERM, 3 NEG_CYCLE
- out_last  out  1  final beat of walk
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after last beat transfers
- overflow  out  1  sticky until next start: walk hit MAX_LEN without terminator

## Operation
- States: IDLE, READ, WAIT, EMIT, FINISH.
- IDLE: start=1 and n_exist=0 → addr=BASE_ADDR, count=0, go to READ. start=1 and n_exist=1 → load NEG_CYCLE beat (data 0, last 1), go to EMIT. start is ignored outside IDLE. overflow clears on an accepted start.
- READ: mem_rd_en=1, mem_addr=addr; go to WAIT.
- WAIT: capture mem_rdata and classify it:
  - 0 → TERM, last=1
  - all-ones → UNREACH, data=all-ones
  - otherwise → NODE
  - Go to EMIT.
- EMIT: hold out_valid with stable data, kind and last until out_valid&out_ready.
  - On transfer with last=1 → FINISH.
  - Otherwise count+1 and addr+1. If count+1==MAX_LEN → load TERM beat (data 0, last 1), set overflow, stay in EMIT. Else → READ.
- FINISH: done=1 for one cycle, busy falls, go to IDLE.
- Addresses never exceed BASE_ADDR+MAX_LEN−1. The count register is ADDR_W+1 bits wide.

## Timing
- Reset values: state IDLE, out_valid 0, out_data 0, out_kind 0, out_last 0, mem_rd_en 0, mem_addr BASE_ADDR, busy 0, done 0, overflow 0.
- Start accepted at edge 0 → READ at edge 1 → WAIT at edge 2 → first out_valid visible after edge 3. A NEG_CYCLE beat is visible after edge 1.
- Steady-state throughput: one beat per 3 cycles with out_ready held high.
- out_valid never drops without a transfer, and payload never changes while valid&!ready.
- reset=1 in any state → IDLE at the next edge with all outputs at reset values. Any in-flight beat is discarded.
- done and a new start cannot coincide: start in the FINISH cycle is ignored.

## Configuration
- PATH_STREAM_SKIP_UNREACH_EN defined:
  - UNREACH words emit no beat. WAIT goes straight to the increment/MAX_LEN check, then READ.
  - Skipped words still count toward MAX_LEN.
  - out_kind 1 is never produced.
- PATH_STREAM_SKIP_UNREACH_EN undefined: every UNREACH word emits a beat as described above.

## Structure
- Package path_stream_pkg holds:
  - kind encodings (KIND_NODE, KIND_UNREACH, KIND_TERM, KIND_NEG)
  - state enum
  - sentinel helper constants: zero, and all-ones as a function of width
- One sub-module, path_stream_classify: combinational word → kind/last decode, so the sentinel rules are reusable by the host-side checker.

## Test plan
- Memory from BASE_ADDR = 5,3,7,0; ready=1; n_exist=0 → beats NODE 5, NODE 3, NODE 7, TERM 0 (last). done pulses once. Reads at addresses 0–3 only.
- Memory = 5,FFFF,2,0:
  - Without macro → NODE 5, UNREACH FFFF, NODE 2, TERM 0.
  - With PATH_STREAM_SKIP_UNREACH_EN → NODE 5, NODE 2, TERM 0.
- n_exist=1 at start → single NEG_CYCLE beat, data 0, last=1. mem_rd_en never asserts. done follows the transfer.
- out_ready held 0 for 3 cycles while a beat is valid (memory 9,4,0) → payload stable throughout. Sequence 9,4,TERM with no drops or duplicates.
- MAX_LEN=4, memory 1,2,3,4,6 → NODE 1–4, then TERM 0 (last), overflow=1. Address 4 never read.
- reset pulsed during EMIT of the second beat → out_valid=0 and busy=0 after the next edge. A new start re-reads from BASE_ADDR and overflow is 0.

Source files
------------

// File: rtl/path_stream_pkg.sv
// rtl/path_stream_pkg.sv - kind encodings, walker states and sentinel helpers for the path result streamer
package path_stream_pkg;

  localparam logic [1:0] KIND_NODE    = 2'd0;
  localparam logic [1:0] KIND_UNREACH = 2'd1;
  localparam logic [1:0] KIND_TERM    = 2'd2;
  localparam logic [1:0] KIND_NEG     = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    EMIT,
    FINISH
  } state_t;

  // Sentinels are defined on a wide carrier and narrowed by the user to its word width
  localparam int SENTINEL_MAX_W = 64;
  localparam logic [SENTINEL_MAX_W-1:0] SENTINEL_ZERO = '0;

  function automatic logic [SENTINEL_MAX_W-1:0] sentinel_ones(input int width);
    sentinel_ones = {SENTINEL_MAX_W{1'b1}} >> (SENTINEL_MAX_W - width);
  endfunction

endpackage

// File: rtl/path_stream_classify.sv
// rtl/path_stream_classify.sv - combinational result-word decode into kind and last flag
module path_stream_classify
  import path_stream_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] data,
  output logic [1:0]        kind,
  output logic              last
);

  localparam logic [DATA_W-1:0] ZERO_W = DATA_W'(SENTINEL_ZERO);
  localparam logic [DATA_W-1:0] ONES_W = DATA_W'(sentinel_ones(DATA_W));

  // Zero terminates the path, all-ones marks an unreachable node, anything else is a node id
  always_comb begin
    kind = KIND_NODE;
    last = 1'b0;
    if (data == ZERO_W) begin
      kind = KIND_TERM;
      last = 1'b1;
    end else if (data == ONES_W) begin
      kind = KIND_UNREACH;
    end
  end

endmodule

// File: rtl/path_result_streamer.sv
// rtl/path_result_streamer.sv - walks the path result memory and streams classified words; PATH_STREAM_SKIP_UNREACH_EN drops UNREACH beats
module path_result_streamer
  import path_stream_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 14,
  parameter int BASE_ADDR = 0,
  parameter int MAX_LEN   = 16383
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              n_exist,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_kind,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

`ifdef PATH_STREAM_SKIP_UNREACH_EN
  localparam bit SKIP_UNREACH = 1'b1;
`else
  localparam bit SKIP_UNREACH = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   MAX_CNT = (ADDR_W+1)'(MAX_LEN);

  state_t              state, state_n;
  logic [ADDR_W-1:0]   addr, addr_n;
  logic [ADDR_W:0]     count, count_n, count_inc;
  logic [DATA_W-1:0]   data_q, data_n;
  logic [1:0]          kind_q, kind_n;
  logic                last_q, last_n;
  logic                ovf_q, ovf_n;
  logic                step;
  logic [1:0]          cls_kind;
  logic                cls_last;

  path_stream_classify #(
    .DATA_W(DATA_W)
  ) u_classify (
    .data(mem_rdata),
    .kind(cls_kind),
    .last(cls_last)
  );

  assign count_inc = count + (ADDR_W+1)'(1);

  // State and beat registers; reset discards any in-flight beat
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      addr   <= BASE;
      count  <= '0;
      data_q <= '0;
      kind_q <= KIND_NODE;
      last_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      state  <= state_n;
      addr   <= addr_n;
      count  <= count_n;
      data_q <= data_n;
      kind_q <= kind_n;
      last_q <= last_n;
      ovf_q  <= ovf_n;
    end
  end

  // Next-state and beat loading; "step" advances to the next word or forces a TERM at the length limit
  always_comb begin
    state_n = state;
    addr_n  = addr;
    count_n = count;
    data_n  = data_q;
    kind_n  = kind_q;
    last_n  = last_q;
    ovf_n   = ovf_q;
    step    = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          ovf_n = 1'b0;
          if (n_exist) begin
            data_n  = '0;
            kind_n  = KIND_NEG;
            last_n  = 1'b1;
            state_n = EMIT;
          end else begin
            addr_n  = BASE;
            count_n = '0;
            state_n = READ;
          end
        end
      end
      READ: state_n = WAIT;
      WAIT: begin
        if (SKIP_UNREACH && cls_kind == KIND_UNREACH) begin
          step = 1'b1;
        end else begin
          data_n  = mem_rdata;
          kind_n  = cls_kind;
          last_n  = cls_last;
          state_n = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (last_q) state_n = FINISH;
          else        step    = 1'b1;
        end
      end
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // The address is left unchanged at the limit so it never points past the last legal word
    if (step) begin
      count_n = count_inc;
      if (count_inc == MAX_CNT) begin
        data_n  = '0;
        kind_n  = KIND_TERM;
        last_n  = 1'b1;
        ovf_n   = 1'b1;
        state_n = EMIT;
      end else begin
        addr_n  = addr + ADDR_W'(1);
        state_n = READ;
      end
    end
  end

  assign mem_rd_en = (state == READ);
  assign mem_addr  = addr;
  assign out_valid = (state == EMIT);
  assign out_data  = data_q;
  assign out_kind  = kind_q;
  assign out_last  = last_q;
  assign busy      = (state == READ) || (state == WAIT) || (state == EMIT);
  assign done      = (state == FINISH);
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_path_result_streamer.sv
// tb/tb_path_result_streamer.sv - table-driven and randomized bench for path_result_streamer
module tb_path_result_streamer;
  import path_stream_pkg::*;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 14;
  localparam int MAX_LEN = 4;
`ifdef PATH_STREAM_SKIP_UNREACH_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef logic [18:0] beat_t;

  typedef struct {
    logic [0:5][15:0] words;
    logic             nex;
    int               mode;
    int               n;
    logic [0:5][18:0] beats;
    logic             ovf;
    int               reads;
    int               lat;
  } vec_t;

  logic clock = 1'b0;
  logic reset, start, n_exist, mem_rd_en, out_valid, out_ready, out_last, busy, done, overflow;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_kind;
  logic [DATA_W-1:0] mem [0:15];

  int    tests = 0;
  int    fails = 0;
  beat_t exp_q[$];
  beat_t got_q[$];
  int    rd_q[$];
  int    exp_reads, exp_lat, done_cnt, first_valid;
  logic  exp_ovf;
  vec_t  vecs[7];

  always #5 clock = ~clock;

  path_result_streamer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BASE_ADDR(0), .MAX_LEN(MAX_LEN)
  ) u_dut (
    .clock(clock), .reset(reset), .start(start), .n_exist(n_exist),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_kind(out_kind), .out_last(out_last), .busy(busy), .done(done),
    .overflow(overflow)
  );

  always @(posedge clock) if (mem_rd_en) mem_rdata <= mem[mem_addr[3:0]];

  function automatic beat_t mk(input logic [15:0] d, input logic [1:0] k, input logic l);
    return {d, k, l};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic load_mem(input logic [0:5][15:0] w);
    for (int i = 0; i < 16; i++) mem[i] = '0;
    for (int i = 0; i < 6; i++) mem[i] = w[i];
  endtask

  // Reference: walk the words by the sentinel rules, stopping at a zero or at MAX_LEN words
  task automatic model(input logic nex);
    int   skips;
    logic lead, ended;
    exp_q.delete();
    exp_reads = 0;
    exp_ovf   = 1'b0;
    skips     = 0;
    lead      = 1'b1;
    ended     = 1'b0;
    if (nex) begin
      exp_q.push_back(mk(16'h0, KIND_NEG, 1'b1));
      exp_lat = 1;
      return;
    end
    for (int i = 0; i < MAX_LEN && !ended; i++) begin
      exp_reads++;
      if (mem[i] == 16'h0000) begin
        exp_q.push_back(mk(16'h0, KIND_TERM, 1'b1));
        ended = 1'b1;
        lead  = 1'b0;
      end else if (mem[i] == 16'hFFFF) begin
        if (SKIP) begin
          if (lead) skips++;
        end else begin
          exp_q.push_back(mk(16'hFFFF, KIND_UNREACH, 1'b0));
          lead = 1'b0;
        end
      end else begin
        exp_q.push_back(mk(mem[i], KIND_NODE, 1'b0));
        lead = 1'b0;
      end
    end
    if (!ended) begin
      exp_q.push_back(mk(16'h0, KIND_TERM, 1'b1));
      exp_ovf = 1'b1;
    end
    exp_lat = (skips == MAX_LEN) ? 1 + 2 * MAX_LEN : 3 + 2 * skips;
  endtask

  // Drive one walk; mode 0 ready high, 1 random ready, 2 ready low for the first 3 valid cycles
  task automatic run_walk(input logic nex, input int mode);
    int    stall, cyc;
    logic  pv, pr, fin;
    beat_t pb;
    got_q.delete();
    rd_q.delete();
    done_cnt    = 0;
    first_valid = -1;
    stall       = 3;
    pv          = 1'b0;
    pr          = 1'b0;
    pb          = '0;
    fin         = 1'b0;
    cyc         = 0;
    @(negedge clock);
    start   = 1'b1;
    n_exist = nex;
    while (!fin && cyc < 200) begin
      @(negedge clock);
      cyc++;
      start   = 1'b0;
      n_exist = 1'b0;
      if (cyc == 1) check("busy_after_start", 32'(busy), 32'd1);
      if (pv && !pr)
        check("hold_stable", 32'({out_valid, out_data, out_kind, out_last}), 32'({1'b1, pb}));
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: begin
          if (out_valid && stall > 0) begin
            out_ready = 1'b0;
            stall--;
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (out_valid && out_ready) got_q.push_back({out_data, out_kind, out_last});
      if (mem_rd_en) rd_q.push_back(int'(mem_addr));
      if (done) begin
        done_cnt++;
        fin     = 1'b1;
        start   = 1'b1;
        n_exist = 1'b1;
      end
      pv = out_valid;
      pr = out_ready;
      pb = {out_data, out_kind, out_last};
    end
    check("walk_finished", 32'(fin), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      start   = 1'b0;
      n_exist = 1'b0;
      if (done) done_cnt++;
      if (mem_rd_en) rd_q.push_back(int'(mem_addr));
      check("idle_after_done", 32'({busy, out_valid}), 32'd0);
    end
  endtask

  task automatic compare(input string tag);
    check({tag, "_beats"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_beat"}, 32'(got_q[i]), 32'(exp_q[i]));
    check({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, "_reads"}, 32'(rd_q.size()), 32'(exp_reads));
    for (int i = 0; i < rd_q.size(); i++)
      check({tag, "_rd_addr"}, 32'(rd_q[i]), 32'(i));
    check({tag, "_latency"}, 32'(first_valid), 32'(exp_lat));
  endtask

  initial begin
    int trans, cyc;

    vecs[0] = '{words: {16'd5, 16'd3, 16'd7, 16'd0, 16'd0, 16'd0}, nex: 1'b0, mode: 0, n: 4,
                beats: {mk(16'd5, KIND_NODE, 1'b0), mk(16'd3, KIND_NODE, 1'b0), mk(16'd7, KIND_NODE, 1'b0),
                        mk(16'd0, KIND_TERM, 1'b1), 19'd0, 19'd0}, ovf: 1'b0, reads: 4, lat: 3};
`ifdef PATH_STREAM_SKIP_UNREACH_EN
    vecs[1] = '{words: {16'd5, 16'hFFFF, 16'd2, 16'd0, 16'd0, 16'd0}, nex: 1'b0, mode: 0, n: 3,
                beats: {mk(16'd5, KIND_NODE, 1'b0), mk(16'd2, KIND_NODE, 1'b0), mk(16'd0, KIND_TERM, 1'b1),
                        19'd0, 19'd0, 19'd0}, ovf: 1'b0, reads: 4, lat: 3};
    vecs[6] = '{words: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd0, 16'd0}, nex: 1'b0, mode: 1, n: 1,
                beats: {mk(16'd0, KIND_TERM, 1'b1), 19'd0, 19'd0, 19'd0, 19'd0, 19'd0},
                ovf: 1'b1, reads: 4, lat: 9};
`else
    vecs[1] = '{words: {16'd5, 16'hFFFF, 16'd2, 16'd0, 16'd0, 16'd0}, nex: 1'b0, mode: 0, n: 4,
                beats: {mk(16'd5, KIND_NODE, 1'b0), mk(16'hFFFF, KIND_UNREACH, 1'b0), mk(16'd2, KIND_NODE, 1'b0),
                        mk(16'd0, KIND_TERM, 1'b1), 19'd0, 19'd0}, ovf: 1'b0, reads: 4, lat: 3};
    vecs[6] = '{words: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd0, 16'd0}, nex: 1'b0, mode: 1, n: 5,
                beats: {mk(16'hFFFF, KIND_UNREACH, 1'b0), mk(16'hFFFF, KIND_UNREACH, 1'b0),
                        mk(16'hFFFF, KIND_UNREACH, 1'b0), mk(16'hFFFF, KIND_UNREACH, 1'b0),
                        mk(16'd0, KIND_TERM, 1'b1), 19'd0}, ovf: 1'b1, reads: 4, lat: 3};
`endif
    vecs[2] = '{words: {16'd1, 16'd2, 16'd0, 16'd0, 16'd0, 16'd0}, nex: 1'b1, mode: 0, n: 1,
                beats: {mk(16'd0, KIND_NEG, 1'b1), 19'd0, 19'd0, 19'd0, 19'd0, 19'd0},
                ovf: 1'b0, reads: 0, lat: 1};
    vecs[3] = '{words: {16'd9, 16'd4, 16'd0, 16'd0, 16'd0, 16'd0}, nex: 1'b0, mode: 2, n: 3,
                beats: {mk(16'd9, KIND_NODE, 1'b0), mk(16'd4, KIND_NODE, 1'b0), mk(16'd0, KIND_TERM, 1'b1),
                        19'd0, 19'd0, 19'd0}, ovf: 1'b0, reads: 3, lat: 3};
    vecs[4] = '{words: {16'd1, 16'd2, 16'd3, 16'd4, 16'd6, 16'd0}, nex: 1'b0, mode: 0, n: 5,
                beats: {mk(16'd1, KIND_NODE, 1'b0), mk(16'd2, KIND_NODE, 1'b0), mk(16'd3, KIND_NODE, 1'b0),
                        mk(16'd4, KIND_NODE, 1'b0), mk(16'd0, KIND_TERM, 1'b1), 19'd0}, ovf: 1'b1, reads: 4, lat: 3};
    vecs[5] = '{words: {16'd0, 16'd7, 16'd0, 16'd0, 16'd0, 16'd0}, nex: 1'b0, mode: 1, n: 1,
                beats: {mk(16'd0, KIND_TERM, 1'b1), 19'd0, 19'd0, 19'd0, 19'd0, 19'd0},
                ovf: 1'b0, reads: 1, lat: 3};

    reset     = 1'b1;
    start     = 1'b0;
    n_exist   = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (3) @(negedge clock);
    check("reset_outputs", 32'({out_valid, out_data, out_kind, out_last, mem_rd_en, busy, done, overflow}), 32'd0);
    check("reset_addr", 32'(mem_addr), 32'd0);
    reset = 1'b0;

    for (int v = 0; v < 7; v++) begin
      load_mem(vecs[v].words);
      exp_q.delete();
      for (int i = 0; i < vecs[v].n; i++) exp_q.push_back(vecs[v].beats[i]);
      exp_ovf   = vecs[v].ovf;
      exp_reads = vecs[v].reads;
      exp_lat   = vecs[v].lat;
      run_walk(vecs[v].nex, vecs[v].mode);
      compare($sformatf("vec%0d", v));
    end

    repeat (3) @(negedge clock);
    check("overflow_sticky", 32'(overflow), 32'd1);

    // Reset while the second beat is pending, then a clean walk from the base address
    load_mem({16'd5, 16'd3, 16'd7, 16'd0, 16'd0, 16'd0});
    @(negedge clock);
    start     = 1'b1;
    out_ready = 1'b1;
    trans     = 0;
    cyc       = 0;
    while (cyc < 50 && !(out_valid && trans == 1)) begin
      @(negedge clock);
      start = 1'b0;
      cyc++;
      if (out_valid && out_ready && trans == 0) begin
        trans = 1;
        @(negedge clock);
        cyc++;
      end
    end
    check("second_beat_reached", 32'(out_valid && trans == 1), 32'd1);
    check("second_beat_data", 32'(out_data), 32'd3);
    out_ready = 1'b0;
    reset     = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mid_reset_valid_busy", 32'({out_valid, busy, done, overflow}), 32'd0);
    check("mid_reset_addr", 32'(mem_addr), 32'd0);
    model(1'b0);
    run_walk(1'b0, 0);
    compare("after_reset");

    for (int r = 0; r < 40; r++) begin
      logic nex;
      for (int i = 0; i < 16; i++) mem[i] = '0;
      for (int i = 0; i < 6; i++) begin
        int p;
        p = int'($urandom_range(0, 9));
        if (p < 2)      mem[i] = 16'h0000;
        else if (p < 4) mem[i] = 16'hFFFF;
        else            mem[i] = 16'($urandom_range(1, 16'hFFFE));
      end
      nex = ($urandom_range(0, 7) == 0);
      model(nex);
      run_walk(nex, int'($urandom_range(0, 1)));
      compare("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
